cmd_arbiter: RTL

- Shares the single cmd_proc command/response channel between two requesters: the UART host (port A) and the tour sequencer (port B).
- UART commands are buffered in a small FIFO. This lets host traffic arriving mid-tour wait instead of colliding with tour moves.
- Grants one command at a time, presents it to cmd_proc with a cmd_rdy handshake, and routes cmd_proc's send_resp back to the owning requester.

---
 rtl/cmd_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cmd_arbiter.sv
// Arbitrates the single cmd_proc channel between the UART host (port A, FIFO-buffered)
// and the tour sequencer (port B, priority). Every output is driven from a flop.
module cmd_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CMD_W-1:0]              cmd_a,
    input  logic                          cmd_rdy_a,
    output logic                          clr_a,
    input  logic [CMD_W-1:0]              cmd_b,
    input  logic                          cmd_rdy_b,
    output logic                          clr_b,
    input  logic                          tour_active,
    output logic [CMD_W-1:0]              cmd,
    output logic                          cmd_rdy,
    input  logic                          clr_cmd_rdy,
    input  logic                          send_resp,
    output logic                          resp_vld_a,
    output logic                          resp_vld_b,
    output logic                          owner,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [CMD_W-1:0] cmd_q,     cmd_d;
    logic             owner_q,   owner_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             busy_q,    busy_d;
    logic             clr_a_q,   clr_a_d;
    logic             clr_b_q,   clr_b_d;
    logic             resp_a_q,  resp_a_d;
    logic             resp_b_q,  resp_b_d;
    logic [PW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [CMD_W-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic fifo_full;

    assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        owner_d   = owner_q;
        clr_b_d   = 1'b0;
        resp_a_d  = 1'b0;
        resp_b_d  = 1'b0;
        pop       = 1'b0;
        // clr_a_q guard keeps a still-held cmd_rdy_a from being pushed twice
        push      = cmd_rdy_a && !fifo_full && !clr_a_q;
        clr_a_d   = push;

        case (state_q)
            IDLE: begin
                if (cmd_rdy_b && !clr_b_q) begin
                    cmd_d   = cmd_b;
                    owner_d = 1'b1;
                    state_d = ISSUE;
                end else if (cnt_q != '0 && !tour_active) begin
                    pop     = 1'b1;
                    cmd_d   = mem_q[rd_ptr_q];
                    owner_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (clr_cmd_rdy) begin
                    clr_b_d = owner_q;
                    if (send_resp) begin
                        resp_a_d = !owner_q;
                        resp_b_d = owner_q;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (send_resp) begin
                    resp_a_d = !owner_q;
                    resp_b_d = owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_rdy_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            owner_q   <= 1'b0;
            cmd_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            clr_a_q   <= 1'b0;
            clr_b_q   <= 1'b0;
            resp_a_q  <= 1'b0;
            resp_b_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            owner_q   <= owner_d;
            cmd_rdy_q <= cmd_rdy_d;
            busy_q    <= busy_d;
            clr_a_q   <= clr_a_d;
            clr_b_q   <= clr_b_d;
            resp_a_q  <= resp_a_d;
            resp_b_q  <= resp_b_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in cnt_q
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_a;
    end

    assign clr_a      = clr_a_q;
    assign clr_b      = clr_b_q;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign resp_vld_a = resp_a_q;
    assign resp_vld_b = resp_b_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign fifo_cnt   = cnt_q;

endmodule
